// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- pipeline sequencer for the 5-stage CPU.
//
// Drives the write-enable, flush and bubble controls of the PC, IF/ID,
// ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, taken
// branches resolved in MEM, and data-memory wait states. A watchdog halts
// the pipe after TIMEOUT consecutive busy cycles; only reset leaves HALT.
//
// Ports:
//   clk, rst (async, active-low)
//   id_rs, id_rt, id_uses_rt     source operands of the instruction in ID
//   ex_memread, ex_rt            load in EX and its destination
//   mem_branch_taken             branch in MEM resolved taken
//   mem_busy                     data memory not ready this cycle
//   pc_wen ... memwb_bubble      pipeline-register controls (combinational)
//   halted                       sticky watchdog halt
//   stall_cnt, flush_cnt         saturating performance counters
//
// Build option: define PERF_CNT_EN to implement the performance counters;
// without it stall_cnt and flush_cnt are tied to zero.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_W   = 5,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_branch_taken,
  input  logic             mem_busy,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             ifid_flush,
  output logic             idex_wen,
  output logic             idex_bubble,
  output logic             exmem_wen,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    HALT
  } state_t;

  state_t              state, stateNext;
  logic [WAIT_W-1:0]   waitCnt, waitCntNext;
  logic                loadUse;

  // Register 0 is hardwired, so a load targeting it can never create a hazard.
  assign loadUse = ex_memread && (ex_rt != '0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  always_comb begin
    stateNext    = state;
    waitCntNext  = '0;
    pc_wen       = 1'b1;
    ifid_wen     = 1'b1;
    ifid_flush   = 1'b0;
    idex_wen     = 1'b1;
    idex_bubble  = 1'b0;
    exmem_wen    = 1'b1;
    exmem_flush  = 1'b0;
    memwb_bubble = 1'b0;
    halted       = 1'b0;

    if (state == HALT) begin
      pc_wen       = 1'b0;
      ifid_wen     = 1'b0;
      idex_wen     = 1'b0;
      exmem_wen    = 1'b0;
      memwb_bubble = 1'b1;
      halted       = 1'b1;
    end else begin
      if (mem_busy) begin
        waitCntNext = waitCnt + WAIT_W'(1);
        stateNext   = (waitCnt == WAIT_W'(TIMEOUT - 1)) ? HALT : MEM_WAIT;
      end else begin
        stateNext   = RUN;
      end

      if (mem_busy) begin
        // EX/MEM is frozen, so a pending taken branch re-presents once
        // memory is ready; MEM/WB gets a bubble so WB never retires twice.
        pc_wen       = 1'b0;
        ifid_wen     = 1'b0;
        idex_wen     = 1'b0;
        exmem_wen    = 1'b0;
        memwb_bubble = 1'b1;
      end else if (mem_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        exmem_flush = 1'b1;
      end else if (loadUse) begin
        pc_wen      = 1'b0;
        ifid_wen    = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt, flushCnt;

  // ifid_flush is raised only by a taken-branch flush, so it marks the event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (!pc_wen && (stallCnt != '1))
        stallCnt <= stallCnt + CNT_W'(1);
      if (ifid_flush && (flushCnt != '1))
        flushCnt <= flushCnt + CNT_W'(1);
    end
  end

  assign stall_cnt = stallCnt;
  assign flush_cnt = flushCnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (TIMEOUT=4, CNT_W=4).
module tb_pipe_hazard_ctrl;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_wen, ifid_wen, ifid_flush, idex_wen, idex_bubble,
  //  exmem_wen, exmem_flush, memwb_bubble, halted}
  localparam logic [8:0] DEF_V  = 9'b1_1_0_1_0_1_0_0_0;
  localparam logic [8:0] LU_V   = 9'b0_0_0_1_1_1_0_0_0;
  localparam logic [8:0] BR_V   = 9'b1_1_1_1_1_1_1_0_0;
  localparam logic [8:0] BUSY_V = 9'b0_0_0_0_0_0_0_1_0;
  localparam logic [8:0] HALT_V = 9'b0_0_0_0_0_0_0_1_1;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] id_rs, id_rt, ex_rt;
  logic             id_uses_rt, ex_memread, mem_branch_taken, mem_busy;
  logic             pc_wen, ifid_wen, ifid_flush, idex_wen, idex_bubble;
  logic             exmem_wen, exmem_flush, memwb_bubble, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [8:0]       ctl;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.REG_W(REG_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt),
    .mem_branch_taken(mem_branch_taken), .mem_busy(mem_busy),
    .pc_wen(pc_wen), .ifid_wen(ifid_wen), .ifid_flush(ifid_flush),
    .idex_wen(idex_wen), .idex_bubble(idex_bubble),
    .exmem_wen(exmem_wen), .exmem_flush(exmem_flush),
    .memwb_bubble(memwb_bubble), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  assign ctl = {pc_wen, ifid_wen, ifid_flush, idex_wen, idex_bubble,
                exmem_wen, exmem_flush, memwb_bubble, halted};

  typedef struct {
    logic [REG_W-1:0] rs, rt, exRt;
    logic             usesRt, exMr, br, busy;
    logic [8:0]       expCtl;
    int               expStall, expFlush;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(int rs, int rt, bit usesRt, bit exMr, int exRt,
                              bit br, bit busy, logic [8:0] e, int s, int f);
    vec_t v;
    v.rs = REG_W'(rs); v.rt = REG_W'(rt); v.usesRt = usesRt;
    v.exMr = exMr; v.exRt = REG_W'(exRt); v.br = br; v.busy = busy;
    v.expCtl = e; v.expStall = PERF ? s : 0; v.expFlush = PERF ? f : 0;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic [REG_W-1:0] rs, logic [REG_W-1:0] rt, logic usesRt,
                       logic exMr, logic [REG_W-1:0] exRtV, logic br, logic busy);
    id_rs = rs; id_rt = rt; id_uses_rt = usesRt; ex_memread = exMr;
    ex_rt = exRtV; mem_branch_taken = br; mem_busy = busy;
  endtask

  // Reference model: halt flag, length of the current busy run, event counts.
  bit mHalted;
  int mBusyRun, mStall, mFlush;

  function automatic logic [8:0] refCtl(bit h, bit busy, bit br, bit mr,
                                        int exRtV, int rs, int rt, bit usesRt);
    if (h) return HALT_V;
    if (busy) return BUSY_V;
    if (br) return BR_V;
    if (mr && exRtV != 0 && (exRtV == rs || (usesRt && exRtV == rt))) return LU_V;
    return DEF_V;
  endfunction

  task automatic modelReset();
    mHalted = 0; mBusyRun = 0; mStall = 0; mFlush = 0;
  endtask

  task automatic modelEdge(logic [8:0] e, bit busy);
    if (!e[8]) mStall = (mStall < CNT_MAX) ? mStall + 1 : CNT_MAX;
    if (e[6])  mFlush = (mFlush < CNT_MAX) ? mFlush + 1 : CNT_MAX;
    if (!mHalted) begin
      mBusyRun = busy ? mBusyRun + 1 : 0;
      if (mBusyRun >= TIMEOUT) mHalted = 1;
    end
  endtask

  initial begin
    logic [8:0] e;
    int rs, rt, er;
    bit ur, mr, br, bz;

    // Three idle cycles after reset, then load-use, branch, busy, timeout.
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, DEF_V, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, DEF_V, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, DEF_V, 0, 0);
    vecs[3]  = mk(8, 3, 1, 0, 8, 0, 0, DEF_V, 0, 0);
    vecs[4]  = mk(8, 3, 0, 1, 8, 0, 0, LU_V,  0, 0);
    vecs[5]  = mk(8, 3, 0, 0, 8, 0, 0, DEF_V, 1, 0);
    vecs[6]  = mk(0, 0, 1, 1, 0, 0, 0, DEF_V, 1, 0);
    vecs[7]  = mk(1, 5, 0, 1, 5, 0, 0, DEF_V, 1, 0);
    vecs[8]  = mk(1, 5, 1, 1, 5, 0, 0, LU_V,  1, 0);
    vecs[9]  = mk(8, 3, 0, 1, 8, 1, 0, BR_V,  2, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 1, 1, BUSY_V, 2, 1);
    vecs[11] = mk(0, 0, 0, 0, 0, 1, 1, BUSY_V, 3, 1);
    vecs[12] = mk(0, 0, 0, 0, 0, 1, 1, BUSY_V, 4, 1);
    vecs[13] = mk(0, 0, 0, 0, 0, 1, 0, BR_V,  5, 1);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 1, BUSY_V, 5, 2);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 1, BUSY_V, 6, 2);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 1, BUSY_V, 7, 2);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, DEF_V, 8, 2);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 1, BUSY_V, 8, 2);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 1, BUSY_V, 9, 2);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 1, BUSY_V, 10, 2);
    vecs[21] = mk(0, 0, 0, 0, 0, 0, 1, BUSY_V, 11, 2);
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, HALT_V, 12, 2);
    vecs[23] = mk(2, 2, 1, 1, 2, 1, 0, HALT_V, 13, 2);

    rst = 1'b0;
    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", int'(ctl), int'(DEF_V));
    chk("reset_stall", int'(stall_cnt), 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;

    foreach (vecs[i]) begin
      drive(vecs[i].rs, vecs[i].rt, vecs[i].usesRt, vecs[i].exMr,
            vecs[i].exRt, vecs[i].br, vecs[i].busy);
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), int'(ctl), int'(vecs[i].expCtl));
      chk($sformatf("vec%0d_stall", i), int'(stall_cnt), vecs[i].expStall);
      chk($sformatf("vec%0d_flush", i), int'(flush_cnt), vecs[i].expFlush);
      @(posedge clk) #1;
    end

    // Ten more halted cycles push the stall counter past its ceiling.
    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("halt_sticky", int'(ctl), int'(HALT_V));
    chk("stall_saturate", int'(stall_cnt), PERF ? CNT_MAX : 0);
    chk("flush_after_halt", int'(flush_cnt), PERF ? 2 : 0);

    // Asynchronous reset clears the halt immediately, mid-cycle.
    rst = 1'b0;
    #1;
    chk("async_reset_ctl", int'(ctl), int'(DEF_V));
    chk("async_reset_stall", int'(stall_cnt), 0);
    @(posedge clk) #1;
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    modelReset();

    // Randomized run against the reference model; reset a while after halting.
    for (int cyc = 0; cyc < 600; cyc++) begin
      rs = $urandom_range(0, 3); rt = $urandom_range(0, 3);
      er = $urandom_range(0, 3); ur = $urandom_range(0, 1);
      mr = ($urandom_range(0, 99) < 50); br = ($urandom_range(0, 99) < 20);
      bz = ($urandom_range(0, 99) < 35);
      drive(REG_W'(rs), REG_W'(rt), ur, mr, REG_W'(er), br, bz);
      e = refCtl(mHalted, bz, br, mr, er, rs, rt, ur);
      @(negedge clk);
      chk("rand_ctl", int'(ctl), int'(e));
      chk("rand_stall", int'(stall_cnt), PERF ? mStall : 0);
      chk("rand_flush", int'(flush_cnt), PERF ? mFlush : 0);
      modelEdge(e, bz);
      if (mHalted && ($urandom_range(0, 3) == 0)) begin
        rst = 1'b0;
        #1;
        chk("rand_reset_halted", int'(halted), 0);
        modelReset();
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
      end
      @(posedge clk) #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage CPU. It drives the write-enable, flush and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves load-use hazards, taken branches (resolved in MEM) and data-memory wait states.
- Adds a wait-timeout watchdog that halts the pipe.
- Sits beside the pipeline registers; every control output is consumed in the same cycle it is produced.

Parameters:
- REG_W, 5, register-index width.
- TIMEOUT, 64, consecutive mem_busy cycles that trigger HALT; must be >= 2.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous active-low reset
- id_rs  input  REG_W  rs index of the instruction in ID
- id_rt  input  REG_W  rt index of the instruction in ID
- id_uses_rt  input  1  instruction in ID reads rt as a source
- ex_memread  input  1  instruction in EX is a load
- ex_rt  input  REG_W  destination of the load in EX
- mem_branch_taken  input  1  branch in MEM resolved taken
- mem_busy  input  1  data memory not ready this cycle
- pc_wen  output  1  PC write enable
- ifid_wen  output  1  IF/ID write enable
- ifid_flush  output  1  IF/ID load NOP
- idex_wen  output  1  ID/EX write enable
- idex_bubble  output  1  ID/EX load zeroed control signals
- exmem_wen  output  1  EX/MEM write enable
- exmem_flush  output  1  EX/MEM load zeroed control signals
- memwb_bubble  output  1  MEM/WB load zeroed control signals
- halted  output  1  pipe halted by timeout (sticky)
- stall_cnt  output  CNT_W  cycles with pc_wen=0
- flush_cnt  output  CNT_W  taken-branch flush events

Behaviour:
- Outputs are combinational from the registered state plus the current inputs.
- Default (no event): all *_wen=1 and all flush/bubble=0.
- State machine: RUN, MEM_WAIT, HALT. wait_cnt is a register of width clog2(TIMEOUT+1).
- Reset (rst=0, async): state=RUN, wait_cnt=0, halted=0, counters=0. Outputs then take their RUN defaults.
- Priority, evaluated each cycle: HALT > mem_busy > mem_branch_taken > load-use > default.
- HALT:
  - All *_wen=0.
  - memwb_bubble=1; other flush/bubble signals 0.
  - halted=1.
  - The only exit is reset.
- mem_busy=1 in RUN or MEM_WAIT:
  - pc_wen, ifid_wen, idex_wen, exmem_wen = 0.
  - memwb_bubble=1, so WB never retires twice.
  - Other flush/bubble signals 0.
- Wait counter and state transitions:
  - Next wait_cnt = mem_busy ? wait_cnt+1 : 0.
  - If mem_busy and wait_cnt==TIMEOUT-1: next state HALT. Otherwise next state is mem_busy ? MEM_WAIT : RUN.
  - Result: exactly TIMEOUT consecutive busy cycles cause HALT; TIMEOUT-1 do not.
- Taken branch:
  - mem_branch_taken=1 with mem_busy=0 gives ifid_flush=1, idex_bubble=1, exmem_flush=1, and pc_wen=1 so the target loads.
  - A branch seen during mem_busy is not lost. EX/MEM is frozen, so the branch re-presents and is taken in the first non-busy cycle.
- Load-use hazard (no busy, no branch):
  - Condition: ex_memread=1, ex_rt!=0, and (ex_rt==id_rs, or ex_rt==id_rt with id_uses_rt=1).
  - Response: pc_wen=0, ifid_wen=0, idex_bubble=1.
  - Lasts exactly one cycle, because the bubble clears ex_memread in the next cycle.
- Register index 0 never causes a stall.
- Counters:
  - stall_cnt increments on every edge where pc_wen=0, including HALT.
  - flush_cnt increments on every edge where a taken-branch flush is issued.
  - Both saturate at 2^CNT_W-1; they do not wrap.

Optional Feature:
- PERF_CNT_EN defined: stall_cnt and flush_cnt are implemented as specified above.
- PERF_CNT_EN undefined: no counter flops are implemented, and stall_cnt and flush_cnt are tied to 0.
- Control behaviour is identical either way.

Test Plan:
- Reset: hold rst=0, then release; drive no events for 3 cycles -> all wen=1, flush/bubble=0, halted=0, counters=0.
- Load-use: ex_memread=1, ex_rt=8, id_rs=8 for 1 cycle -> pc_wen=0, ifid_wen=0, idex_bubble=1 for that cycle only, then defaults. Repeat with ex_rt=0 -> no stall.
- Branch vs load-use: mem_branch_taken=1 in the same cycle as a load-use match -> ifid_flush=idex_bubble=exmem_flush=1, pc_wen=1, flush_cnt +1.
- Busy then branch: mem_busy=1 for 3 cycles with mem_branch_taken=1 -> all wen=0 and memwb_bubble=1 for 3 cycles; 4th cycle shows the branch flush; stall_cnt=3.
- Timeout, TIMEOUT=4: mem_busy high for 3 cycles then low -> no halt. mem_busy high for 4 cycles -> halted=1 from the 5th cycle and stays 1 after mem_busy drops, until rst=0.
- Saturation (CNT_W=4, PERF_CNT_EN defined): 20 stall cycles -> stall_cnt=15. Same run with PERF_CNT_EN undefined -> stall_cnt=0.
